vga_timing_rx: RTL

Receive-side VGA timing recovery block: samples incoming HSYNC/VSYNC, measures line length and lines per frame, regenerates pixel coordinates, and reports lock status. It is the counterpart of the horizontal/vertical counter chain that generates display timing. It is used to check generated timing in loopback and to track externally sourced video timing.

---
 rtl/vga_timing_rx.sv | 138 +++++++++++++
 1 files changed

// File: rtl/vga_timing_rx.sv
// Receive-side VGA timing recovery: measures HSYNC period and lines per frame,
// regenerates pixel coordinates and tracks lock on the incoming timing.
module vga_timing_rx #(
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int LOCK_COUNT = 4
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iHSync,
  input  logic        iVSync,
  output logic [15:0] oX,
  output logic [15:0] oY,
  output logic [15:0] oLineLen,
  output logic [15:0] oFrameLines,
  output logic        oNewLine,
  output logic        oNewFrame,
  output logic        oLocked,
  output logic        oError
);

  typedef enum logic [1:0] {HUNT = 2'd0, TRACK = 2'd1, LOCKED = 2'd2} RxState;

  localparam logic [3:0] LockTarget = 4'(LOCK_COUNT - 1);

  RxState      stateQ, stateD;
  logic [3:0]  matchQ, matchD;
  logic [1:0]  lockVsQ, lockVsD;
  logic        errorD;
  logic [2:0]  hPipe, vPipe;
  logic        hEdge, vEdge;
  logic [15:0] xInc, yInc, newLen, newFrame;
  logic        lenEq, frameEq, syncLost;

  // Syncs are normalised to active-high, so reset value 0 is the inactive level.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      hPipe <= '0;
      vPipe <= '0;
    end else begin
      hPipe <= {hPipe[1:0], iHSync == HSYNC_POL};
      vPipe <= {vPipe[1:0], iVSync == VSYNC_POL};
    end
  end

  assign hEdge    = hPipe[1] & ~hPipe[2];
  assign vEdge    = vPipe[1] & ~vPipe[2];
  assign xInc     = (oX == 16'hFFFF) ? oX : oX + 16'd1;
  assign yInc     = (oY == 16'hFFFF) ? oY : oY + 16'd1;
  assign newLen   = oX + 16'd1;
  assign newFrame = oY + 16'd1;
  assign lenEq    = (newLen == oLineLen);
  assign frameEq  = (newFrame == oFrameLines);
  assign syncLost = (oX == 16'hFFFF) && !hEdge;

  // lockVsQ counts VSYNC edges seen in LOCKED; frame checks start once a full
  // locked frame (two edges) has been measured.
  always_comb begin
    stateD  = stateQ;
    matchD  = matchQ;
    lockVsD = lockVsQ;
    errorD  = 1'b0;
    case (stateQ)
      HUNT: begin
        if (hEdge) begin
          stateD = TRACK;
          matchD = '0;
        end
      end
      TRACK: begin
        if (hEdge) begin
          if (lenEq) begin
            matchD = matchQ + 4'd1;
            if (matchD == LockTarget) begin
              stateD  = LOCKED;
              lockVsD = '0;
            end
          end else begin
            matchD = '0;
          end
        end
      end
      LOCKED: begin
        if ((hEdge && !lenEq) || (vEdge && lockVsQ == 2'd2 && !frameEq)) begin
          errorD = 1'b1;
          stateD = TRACK;
          matchD = '0;
        end else if (vEdge && lockVsQ != 2'd2) begin
          lockVsD = lockVsQ + 2'd1;
        end
      end
      default: begin
        stateD = HUNT;
        matchD = '0;
      end
    endcase
    if (syncLost) begin
      stateD = HUNT;
      matchD = '0;
      errorD = 1'b0;
    end
  end

  // The first line after HUNT has no valid start point, so its length is dropped.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      stateQ      <= HUNT;
      matchQ      <= '0;
      lockVsQ     <= '0;
      oX          <= '0;
      oY          <= '0;
      oLineLen    <= '0;
      oFrameLines <= '0;
      oNewLine    <= 1'b0;
      oNewFrame   <= 1'b0;
      oLocked     <= 1'b0;
      oError      <= 1'b0;
    end else begin
      stateQ    <= stateD;
      matchQ    <= matchD;
      lockVsQ   <= lockVsD;
      oNewLine  <= hEdge;
      oNewFrame <= vEdge;
      oLocked   <= (stateD == LOCKED);
      oError    <= errorD;
      oX        <= hEdge ? 16'd0 : xInc;
      if (hEdge && stateQ != HUNT)
        oLineLen <= newLen;
      if (vEdge) begin
        oY          <= '0;
        oFrameLines <= newFrame;
      end else if (hEdge) begin
        oY <= yInc;
      end
    end
  end

endmodule
